cache_repl_ctrl: RTL and testbench

Parametrised replacement-way controller for a set-associative cache, generalising the fixed 4-way/8-set FIFO selector to any power-of-two way and set count. It holds a per-set age table, picks a victim way for each replace request (an invalid way first, otherwise the oldest way), and returns it through a registered valid/ready handshake. After reset it runs a self-initialisation sweep. An optional compile-time feature turns the FIFO policy into true LRU by applying hit updates. It sits beside the tag/valid arrays in the cache controller.

---
 rtl/repl_pkg.sv | 30 +++
 rtl/repl_victim_sel.sv | 40 ++++
 rtl/cache_repl_ctrl.sv | 114 +++++++++++
 tb/tb_cache_repl_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/repl_pkg.sv
// rtl/repl_pkg.sv - shared state enum, age-init rule and victim search helpers for the replacement controller
package repl_pkg;

  localparam int MAX_WAYS  = 64;
  localparam int MAX_WAY_W = 6;

  typedef enum logic {INIT, IDLE} replState_t;

  typedef logic [MAX_WAYS-1:0][MAX_WAY_W-1:0] ageVec_t;

  // Way 0 starts oldest so an untouched set is filled in way order.
  function automatic logic [MAX_WAY_W-1:0] initAge(input int numWays, input int way);
    return MAX_WAY_W'(numWays - 1 - way);
  endfunction

  function automatic logic [MAX_WAY_W-1:0] lowestInvalid(input logic [MAX_WAYS-1:0] validBits);
    lowestInvalid = '0;
    for (int w = MAX_WAYS - 1; w >= 0; w--) begin
      if (!validBits[w]) lowestInvalid = MAX_WAY_W'(w);
    end
  endfunction

  function automatic logic [MAX_WAY_W-1:0] oldestWay(input ageVec_t ages, input int numWays);
    oldestWay = '0;
    for (int w = 0; w < MAX_WAYS; w++) begin
      if (w < numWays && ages[w] == MAX_WAY_W'(numWays - 1)) oldestWay = MAX_WAY_W'(w);
    end
  endfunction

endpackage

// File: rtl/repl_victim_sel.sv
// rtl/repl_victim_sel.sv - combinational victim pick and age touch for one set
module repl_victim_sel
  import repl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] ages,
  input  logic [NUM_WAYS-1:0]            validBits,
  input  logic                           touchOverride,
  input  logic [WAY_W-1:0]               overrideWay,
  output logic [WAY_W-1:0]               victimWay,
  output logic                           wasInvalid,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] touchedAges
);

  ageVec_t             agesWide;
  logic [MAX_WAYS-1:0] validWide;
  logic [WAY_W-1:0]    touchWay;

  always_comb begin
    agesWide  = '0;
    validWide = '1;
    for (int w = 0; w < NUM_WAYS; w++) agesWide[w] = MAX_WAY_W'(ages[w]);
    validWide[NUM_WAYS-1:0] = validBits;

    wasInvalid = ~&validBits;
    victimWay  = wasInvalid ? WAY_W'(lowestInvalid(validWide))
                            : WAY_W'(oldestWay(agesWide, NUM_WAYS));
    // Hit path touches the reported way rather than a selected victim.
    touchWay   = touchOverride ? overrideWay : victimWay;

    touchedAges = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == touchWay)            touchedAges[w] = '0;
      else if (ages[w] < ages[touchWay])    touchedAges[w] = ages[w] + 1'b1;
    end
  end

endmodule

// File: rtl/cache_repl_ctrl.sv
// rtl/cache_repl_ctrl.sv - per-set FIFO/LRU victim selector; REPL_HIT_UPDATE_EN enables hit-driven LRU updates
module cache_repl_ctrl
  import repl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 8,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                req_valid,
  input  logic [SET_W-1:0]    req_set,
  input  logic [NUM_WAYS-1:0] req_valid_bits,
  output logic                rsp_valid,
  output logic [WAY_W-1:0]    rsp_way,
  output logic                rsp_was_invalid,
  input  logic                hit_valid,
  input  logic [SET_W-1:0]    hit_set,
  input  logic [WAY_W-1:0]    hit_way
);

  replState_t                     state, stateNext;
  logic [SET_W-1:0]               initPtr;
  logic [NUM_WAYS-1:0][WAY_W-1:0] ageTable [NUM_SETS];

  logic                           accept;
  logic [WAY_W-1:0]               fillWay;
  logic                           fillInvalid;
  logic [NUM_WAYS-1:0][WAY_W-1:0] fillAges;
  logic                           hitEn;
  logic [NUM_WAYS-1:0][WAY_W-1:0] hitAges;

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    ready     = 1'b0;
    case (state)
      INIT: if (initPtr == SET_W'(NUM_SETS - 1)) stateNext = IDLE;
      IDLE: ready = 1'b1;
    endcase
  end

  assign accept = req_valid && ready;

  always_ff @(posedge clk) begin
    if (reset)              initPtr <= '0;
    else if (state == INIT) initPtr <= initPtr + 1'b1;
  end

  // Table has no reset of its own; the INIT sweep rewrites every set.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int w = 0; w < NUM_WAYS; w++) ageTable[initPtr][w] <= WAY_W'(initAge(NUM_WAYS, w));
    end else begin
      if (accept) ageTable[req_set] <= fillAges;
      if (hitEn)  ageTable[hit_set] <= hitAges;
    end
  end

  repl_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) fillSel (
    .ages          (ageTable[req_set]),
    .validBits     (req_valid_bits),
    .touchOverride (1'b0),
    .overrideWay   ('0),
    .victimWay     (fillWay),
    .wasInvalid    (fillInvalid),
    .touchedAges   (fillAges)
  );

`ifdef REPL_HIT_UPDATE_EN
  logic [WAY_W-1:0] unusedHitWay;
  logic             unusedHitInvalid;

  // A replace to the same set wins; the hit is dropped.
  assign hitEn = hit_valid && ready && !(accept && hit_set == req_set);

  repl_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) hitSel (
    .ages          (ageTable[hit_set]),
    .validBits     ('1),
    .touchOverride (1'b1),
    .overrideWay   (hit_way),
    .victimWay     (unusedHitWay),
    .wasInvalid    (unusedHitInvalid),
    .touchedAges   (hitAges)
  );
`else
  logic unusedHit;

  assign hitEn     = 1'b0;
  assign hitAges   = '0;
  assign unusedHit = ^{hit_valid, hit_set, hit_way};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid       <= 1'b0;
      rsp_way         <= '0;
      rsp_was_invalid <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_way         <= fillWay;
        rsp_was_invalid <= fillInvalid;
      end
    end
  end

endmodule

// File: tb/tb_cache_repl_ctrl.sv
// tb/tb_cache_repl_ctrl.sv - randomized bench for cache_repl_ctrl against a recency-list model (honours REPL_HIT_UPDATE_EN)
module tb_cache_repl_ctrl;

  localparam int NW = 4;
  localparam int NS = 8;
  localparam int WW = 2;
  localparam int SW = 3;
`ifdef REPL_HIT_UPDATE_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          req_valid;
  logic [SW-1:0] req_set;
  logic [NW-1:0] req_valid_bits;
  logic          rsp_valid;
  logic [WW-1:0] rsp_way;
  logic          rsp_was_invalid;
  logic          hit_valid;
  logic [SW-1:0] hit_set;
  logic [WW-1:0] hit_way;

  cache_repl_ctrl #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk             (clk),
    .reset           (reset),
    .ready           (ready),
    .req_valid       (req_valid),
    .req_set         (req_set),
    .req_valid_bits  (req_valid_bits),
    .rsp_valid       (rsp_valid),
    .rsp_way         (rsp_way),
    .rsp_was_invalid (rsp_was_invalid),
    .hit_valid       (hit_valid),
    .hit_set         (hit_set),
    .hit_way         (hit_way)
  );

  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;
  int expWayHold = 0;
  int expInvHold = 0;

  // order[s][0] is the least recently filled/touched way, order[s][NW-1] the most recent.
  int order [NS][NW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelInit();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < NW; i++) order[s][i] = i;
  endtask

  task automatic modelVictim(input int s, input logic [NW-1:0] vb, output int way, output int inv);
    way = -1;
    for (int w = NW - 1; w >= 0; w--) if (!vb[w]) way = w;
    inv = (way >= 0) ? 1 : 0;
    if (way < 0) way = order[s][0];
  endtask

  task automatic modelTouch(input int s, input int way);
    int p;
    p = 0;
    for (int i = 0; i < NW; i++) if (order[s][i] == way) p = i;
    for (int i = p; i < NW - 1; i++) order[s][i] = order[s][i+1];
    order[s][NW-1] = way;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doCycle(input bit rv, input int rs, input logic [NW-1:0] vb,
                         input bit hv, input int hs, input int hw, input string tag);
    int ew, ei;
    req_valid      = rv;
    req_set        = SW'(rs);
    req_valid_bits = vb;
    hit_valid      = hv;
    hit_set        = SW'(hs);
    hit_way        = WW'(hw);
    if (rv) begin
      modelVictim(rs, vb, ew, ei);
      modelTouch(rs, ew);
      expWayHold = ew;
      expInvHold = ei;
    end
    if (hv && HIT_EN && !(rv && hs == rs)) modelTouch(hs, hw);
    step();
    req_valid = 1'b0;
    hit_valid = 1'b0;
    check({tag, ".vld"}, 32'(rsp_valid), 32'(rv));
    check({tag, ".way"}, 32'(rsp_way), expWayHold);
    check({tag, ".inv"}, 32'(rsp_was_invalid), expInvHold);
    check({tag, ".rdy"}, 32'(ready), 1);
  endtask

  task automatic doReset(input bit withReq);
    reset          = 1'b1;
    req_valid      = withReq;
    req_set        = 3'd2;
    req_valid_bits = '1;
    hit_valid      = 1'b0;
    hit_set        = '0;
    hit_way        = '0;
    step();
    check("rst.vld", 32'(rsp_valid), 0);
    check("rst.way", 32'(rsp_way), 0);
    check("rst.inv", 32'(rsp_was_invalid), 0);
    check("rst.rdy", 32'(ready), 0);
    req_valid = 1'b0;
    step();
    reset = 1'b0;
    modelInit();
    expWayHold = 0;
    expInvHold = 0;
    // Requests and hits during the sweep must be ignored.
    for (int i = 0; i < NS; i++) begin
      check("init.rdy", 32'(ready), 0);
      check("init.vld", 32'(rsp_valid), 0);
      req_valid = 1'b1;
      req_set   = SW'(i);
      hit_valid = 1'b1;
      hit_set   = SW'(i);
      hit_way   = WW'(i + 1);
      step();
    end
    req_valid = 1'b0;
    hit_valid = 1'b0;
    check("init.vldEnd", 32'(rsp_valid), 0);
    check("init.rdyEnd", 32'(ready), 1);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_set        = '0;
    req_valid_bits = '1;
    hit_valid      = 1'b0;
    hit_set        = '0;
    hit_way        = '0;
    modelInit();

    doReset(1'b0);

    for (int i = 0; i < NW; i++) begin
      doCycle(1, 0, 4'hF, 0, 0, 0, "set0");
      check("set0.const", 32'(rsp_way), i);
    end
    for (int i = 0; i < 5; i++) begin
      doCycle(1, 2, 4'hF, 0, 0, 0, "set2");
      check("set2.const", 32'(rsp_way), i % NW);
    end

    doCycle(1, 4, 4'b1011, 0, 0, 0, "set4a");
    check("set4a.const", 32'(rsp_way), 2);
    check("set4a.constInv", 32'(rsp_was_invalid), 1);
    doCycle(1, 4, 4'hF, 0, 0, 0, "set4b");
    check("set4b.const", 32'(rsp_way), 0);
    check("set4b.constInv", 32'(rsp_was_invalid), 0);

    doCycle(1, 5, 4'hF, 0, 0, 0, "set5a");
    check("set5a.const", 32'(rsp_way), 0);
    doCycle(0, 0, 4'hF, 1, 5, 1, "set5hit");
    doCycle(1, 5, 4'hF, 0, 0, 0, "set5b");
    check("set5b.const", 32'(rsp_way), HIT_EN ? 2 : 1);

    doCycle(1, 3, 4'hF, 1, 3, 0, "same");
    check("same.const", 32'(rsp_way), 0);
    doCycle(1, 6, 4'hF, 1, 3, 1, "diff");
    check("diff.const", 32'(rsp_way), 0);
    doCycle(1, 3, 4'hF, 0, 0, 0, "set3");
    check("set3.const", 32'(rsp_way), HIT_EN ? 2 : 1);

    doReset(1'b1);
    doCycle(1, 2, 4'hF, 0, 0, 0, "postRst");
    check("postRst.const", 32'(rsp_way), 0);

    for (int n = 0; n < 400; n++) begin
      bit            rv, hv;
      int            rs, hs, hw;
      logic [NW-1:0] vb;
      rv = ($urandom_range(0, 3) != 0);
      rs = $urandom_range(0, NS - 1);
      vb = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '1;
      hv = ($urandom_range(0, 1) != 0);
      hs = ($urandom_range(0, 3) == 0) ? rs : $urandom_range(0, NS - 1);
      hw = $urandom_range(0, NW - 1);
      doCycle(rv, rs, vb, hv, hs, hw, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
